// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared types and constants for the IF/MEM backing-memory arbiter
//
// Holds the arbiter FSM encodings, the word returned on a timeout abort, the
// default arbitration/timeout limits and the counter width helper.

package mips_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } arb_state_t;

    localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

    localparam int STREAK_MAX_DEFAULT = 4;
    localparam int TIMEOUT_DEFAULT    = 255;

    // Bits needed to hold the values 0..max_val (never less than one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// rtl/arb_sat_counter.sv - synchronous saturating up-counter with clear
//
// Ports:
//   clk    in   clock
//   reset  in   synchronous active-high reset
//   clr    in   clear to zero (wins over inc)
//   inc    in   increment by one, holding at MAX
//   count  out  W-bit current value

module arb_sat_counter #(
    parameter int MAX = 4,
    parameter int W   = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic at_max;

    assign at_max = (count == MAX_V);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/MEM arbiter onto one single-ported variable-latency memory
//
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   if_req/if_addr -> if_rdata/if_ready   fetch port (read-only), ready is a 1-cycle pulse
//   d_req/d_we/d_addr/d_wdata -> d_rdata/d_ready   data port, ready is a 1-cycle pulse
//   m_req/m_we/m_addr/m_wdata, m_rdata/m_ack   memory req/ack handshake
//   bus_err                           sticky timeout-abort flag, cleared only by reset
//
// Data port has priority; after STREAK_MAX consecutive data grants with a
// fetch waiting, the fetch is granted. An access left unacknowledged for
// TIMEOUT busy cycles is aborted and completed with ERR_WORD.

module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STREAK_MAX = STREAK_MAX_DEFAULT,
    parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ack,
    output logic          bus_err
);

    localparam int SW = cnt_width(STREAK_MAX);
    localparam int TW = cnt_width(TIMEOUT);

    localparam logic [SW-1:0] STREAK_LIMIT = SW'(STREAK_MAX);
    localparam logic [TW-1:0] TMO_LAST     = TW'(TIMEOUT - 1);

    arb_state_t state;
    arb_state_t next_state;

    logic          grant_d;
    logic          grant_i;
    logic          done;
    logic          abort;
    logic          busy;
    logic          streak_sat;
    logic          tmo_limit;
    logic [SW-1:0] streak_cnt;
    logic [TW-1:0] tmo_cnt;

    assign busy = (state == ST_BUSY_I) || (state == ST_BUSY_D);

    // The streak saturates at STREAK_MAX, so equality is the ">= limit" test.
    // With STREAK_MAX = 0 the count is pinned at 0 and fetch always wins.
    assign streak_sat = (streak_cnt == STREAK_LIMIT);

    // True in the TIMEOUT-th consecutive unacknowledged busy cycle.
    assign tmo_limit = (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        grant_d    = 1'b0;
        grant_i    = 1'b0;
        done       = 1'b0;
        abort      = 1'b0;
        case (state)
            ST_IDLE: begin
                // In the ready-pulse cycle the requester still presents the
                // request it just had served, so no grant is made then.
                if (!(if_ready || d_ready)) begin
                    if (d_req && !(if_req && streak_sat)) begin
                        grant_d    = 1'b1;
                        next_state = ST_BUSY_D;
                    end else if (if_req) begin
                        grant_i    = 1'b1;
                        next_state = ST_BUSY_I;
                    end
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                // An ack in the limit cycle takes precedence over the abort.
                if (m_ack) begin
                    done       = 1'b1;
                    next_state = ST_IDLE;
                end else if (tmo_limit) begin
                    abort      = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    arb_sat_counter #(
        .MAX (STREAK_MAX),
        .W   (SW)
    ) u_streak_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (!if_req || grant_i),
        .inc   (grant_d && if_req),
        .count (streak_cnt)
    );

    arb_sat_counter #(
        .MAX (TIMEOUT),
        .W   (TW)
    ) u_tmo_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (!busy || m_ack),
        .inc   (busy && !m_ack),
        .count (tmo_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            if_rdata <= '0;
            if_ready <= 1'b0;
            d_rdata  <= '0;
            d_ready  <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;

            if (grant_d) begin
                m_req   <= 1'b1;
                m_we    <= d_we;
                m_addr  <= d_addr;
                m_wdata <= d_wdata;
            end else if (grant_i) begin
                m_req   <= 1'b1;
                m_we    <= 1'b0;
                m_addr  <= if_addr;
                m_wdata <= '0;
            end

            if (done || abort) begin
                m_req <= 1'b0;
                m_we  <= 1'b0;
                if (state == ST_BUSY_I) begin
                    if_ready <= 1'b1;
                    if_rdata <= abort ? DW'(ERR_WORD) : m_rdata;
                end else begin
                    d_ready <= 1'b1;
                    if (abort) begin
                        d_rdata <= DW'(ERR_WORD);
                    end else begin
                        d_rdata <= m_we ? '0 : m_rdata;
                    end
                end
            end

            if (abort) begin
                bus_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter

module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    // memory model controls
    int          ack_lat   = 0;
    logic        no_ack    = 1'b0;
    logic [31:0] rdata_val = 32'h0;
    int          wait_cnt  = 0;
    logic        prev_mreq = 1'b0;
    logic [31:0] log_addr[$];
    logic        log_we[$];

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW         (32),
        .DW         (32),
        .STREAK_MAX (4),
        .TIMEOUT    (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ready (if_ready),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_ready  (d_ready),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata),
        .m_ack    (m_ack),
        .bus_err  (bus_err)
    );

    // Backing memory: acks after ack_lat cycles of m_req, logs each new grant.
    initial begin
        m_ack   = 1'b0;
        m_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (m_req && !prev_mreq) begin
                log_addr.push_back(m_addr);
                log_we.push_back(m_we);
            end
            prev_mreq = m_req;
            if (m_req && !no_ack) begin
                if (wait_cnt == ack_lat) begin
                    m_ack    = 1'b1;
                    m_rdata  = rdata_val;
                    wait_cnt = 0;
                end else begin
                    m_ack    = 1'b0;
                    wait_cnt = wait_cnt + 1;
                end
            end else begin
                m_ack    = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset   = 1'b1;
        if_req  = 1'b0;
        if_addr = 32'h0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = 32'h0;
        d_wdata = 32'h0;
        tick;
        tick;
        checks++;
        if (m_req !== 1'b0 || m_we !== 1'b0 || if_ready !== 1'b0 || d_ready !== 1'b0 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: m_req=%b m_we=%b if_ready=%b d_ready=%b bus_err=%b, expected all 0",
                     m_req, m_we, if_ready, d_ready, bus_err);
        end
        checks++;
        if (m_addr !== 32'h0 || m_wdata !== 32'h0 || if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: m_addr=%h m_wdata=%h if_rdata=%h d_rdata=%h, expected all 0",
                     m_addr, m_wdata, if_rdata, d_rdata);
        end
        reset = 1'b0;
        tick;
    endtask

    task automatic test_load;
        ack_lat   = 1;
        no_ack    = 1'b0;
        rdata_val = 32'h0000_1234;
        d_we      = 1'b0;
        d_addr    = 32'h40;
        d_req     = 1'b1;
        tick;
        checks++;
        if (m_req !== 1'b1 || m_addr !== 32'h40 || m_we !== 1'b0) begin
            errors++;
            $display("FAIL load_mreq: m_req=%b m_addr=%h m_we=%b, expected 1 00000040 0", m_req, m_addr, m_we);
        end
        tick;
        checks++;
        if (d_ready !== 1'b0 || m_req !== 1'b1) begin
            errors++;
            $display("FAIL load_wait: d_ready=%b m_req=%b, expected 0 1", d_ready, m_req);
        end
        tick;
        checks++;
        if (d_ready !== 1'b1 || d_rdata !== 32'h0000_1234) begin
            errors++;
            $display("FAIL load_ready: d_ready=%b d_rdata=%h, expected 1 00001234", d_ready, d_rdata);
        end
        checks++;
        if (if_ready !== 1'b0 || m_req !== 1'b0) begin
            errors++;
            $display("FAIL load_side: if_ready=%b m_req=%b, expected 0 0", if_ready, m_req);
        end
        d_req = 1'b0;
        tick;
        checks++;
        if (d_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_pulse: d_ready=%b, expected 0", d_ready);
        end
        tick;
    endtask

    task automatic test_both_request;
        bit got;
        ack_lat   = 0;
        rdata_val = 32'h1111_2222;
        log_addr.delete();
        log_we.delete();
        if_addr = 32'h0;
        d_addr  = 32'h80;
        d_we    = 1'b0;
        if_req  = 1'b1;
        d_req   = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick;
            if (d_ready === 1'b1) got = 1'b1;
        end
        d_req = 1'b0;
        checks++;
        if (!got || if_ready !== 1'b0) begin
            errors++;
            $display("FAIL both_d_first: d_ready_seen=%b if_ready=%b, expected 1 0", got, if_ready);
        end
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick;
            if (if_ready === 1'b1) got = 1'b1;
        end
        if_req = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL both_if_done: if_ready_seen=%b, expected 1", got);
        end
        tick;
        tick;
        checks++;
        if (log_addr.size() != 2) begin
            errors++;
            $display("FAIL both_count: grants=%0d, expected 2", log_addr.size());
        end else begin
            checks++;
            if (log_addr[0] !== 32'h80 || log_addr[1] !== 32'h0 || log_we[1] !== 1'b0) begin
                errors++;
                $display("FAIL both_order: g0=%h g1=%h g1_we=%b, expected 00000080 00000000 0",
                         log_addr[0], log_addr[1], log_we[1]);
            end
        end
    endtask

    task automatic test_starvation;
        logic [31:0] exp_addr;
        ack_lat = 0;
        log_addr.delete();
        log_we.delete();
        if_addr = 32'h4;
        d_addr  = 32'h80;
        d_we    = 1'b0;
        if_req  = 1'b1;
        d_req   = 1'b1;
        for (int k = 0; k < 100 && log_addr.size() < 10; k++) begin
            tick;
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        for (int k = 0; k < 6; k++) tick;
        checks++;
        if (log_addr.size() < 10) begin
            errors++;
            $display("FAIL starve_count: grants=%0d, expected at least 10", log_addr.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                exp_addr = (i == 4 || i == 9) ? 32'h4 : 32'h80;
                checks++;
                if (log_addr[i] !== exp_addr) begin
                    errors++;
                    $display("FAIL starve_grant%0d: m_addr=%h, expected %h", i, log_addr[i], exp_addr);
                end
            end
        end
    endtask

    task automatic test_store;
        ack_lat   = 0;
        rdata_val = 32'h5555_AAAA;
        d_we      = 1'b1;
        d_wdata   = 32'hCAFE_F00D;
        d_addr    = 32'h10;
        d_req     = 1'b1;
        tick;
        checks++;
        if (m_req !== 1'b1 || m_we !== 1'b1 || m_wdata !== 32'hCAFE_F00D || m_addr !== 32'h10) begin
            errors++;
            $display("FAIL store_mreq: m_req=%b m_we=%b m_wdata=%h m_addr=%h, expected 1 1 cafef00d 00000010",
                     m_req, m_we, m_wdata, m_addr);
        end
        tick;
        checks++;
        if (d_ready !== 1'b1 || d_rdata !== 32'h0 || m_req !== 1'b0) begin
            errors++;
            $display("FAIL store_ready: d_ready=%b d_rdata=%h m_req=%b, expected 1 00000000 0",
                     d_ready, d_rdata, m_req);
        end
        d_req = 1'b0;
        d_we  = 1'b0;
        tick;
        tick;
    endtask

    task automatic test_ack_at_limit;
        ack_lat   = 7;
        no_ack    = 1'b0;
        rdata_val = 32'h600D_CAFE;
        if_addr   = 32'h300;
        if_req    = 1'b1;
        for (int k = 0; k < 8; k++) tick;
        checks++;
        if (m_req !== 1'b1 || if_ready !== 1'b0) begin
            errors++;
            $display("FAIL limit_busy: m_req=%b if_ready=%b, expected 1 0", m_req, if_ready);
        end
        tick;
        checks++;
        if (if_ready !== 1'b1 || if_rdata !== 32'h600D_CAFE || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL limit_ack_wins: if_ready=%b if_rdata=%h bus_err=%b, expected 1 600dcafe 0",
                     if_ready, if_rdata, bus_err);
        end
        if_req = 1'b0;
        tick;
        tick;
    endtask

    task automatic test_timeout;
        no_ack  = 1'b1;
        if_addr = 32'h100;
        if_req  = 1'b1;
        tick;
        checks++;
        if (m_req !== 1'b1 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL tmo_start: m_req=%b bus_err=%b, expected 1 0", m_req, bus_err);
        end
        for (int k = 0; k < 7; k++) tick;
        checks++;
        if (m_req !== 1'b1 || if_ready !== 1'b0) begin
            errors++;
            $display("FAIL tmo_last_busy: m_req=%b if_ready=%b, expected 1 0", m_req, if_ready);
        end
        tick;
        checks++;
        if (m_req !== 1'b0 || if_ready !== 1'b1 || if_rdata !== 32'hDEAD_BEEF || bus_err !== 1'b1) begin
            errors++;
            $display("FAIL tmo_abort: m_req=%b if_ready=%b if_rdata=%h bus_err=%b, expected 0 1 deadbeef 1",
                     m_req, if_ready, if_rdata, bus_err);
        end
        if_req = 1'b0;
        no_ack = 1'b0;
        tick;
        tick;
        checks++;
        if (bus_err !== 1'b1 || if_ready !== 1'b0) begin
            errors++;
            $display("FAIL tmo_sticky: bus_err=%b if_ready=%b, expected 1 0", bus_err, if_ready);
        end
    endtask

    task automatic test_reset_busy;
        bit got;
        no_ack = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h44;
        d_req  = 1'b1;
        tick;
        checks++;
        if (m_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_busy_start: m_req=%b, expected 1", m_req);
        end
        tick;
        reset = 1'b1;
        tick;
        checks++;
        if (m_req !== 1'b0 || d_ready !== 1'b0 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy_clear: m_req=%b d_ready=%b bus_err=%b, expected 0 0 0",
                     m_req, d_ready, bus_err);
        end
        reset  = 1'b0;
        d_req  = 1'b0;
        no_ack = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick;
            if (d_ready === 1'b1 || m_req === 1'b1) got = 1'b1;
        end
        checks++;
        if (got) begin
            errors++;
            $display("FAIL rst_busy_quiet: activity_seen=%b, expected 0", got);
        end
        ack_lat   = 0;
        rdata_val = 32'h0BAD_F00D;
        if_addr   = 32'h200;
        if_req    = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick;
            if (if_ready === 1'b1) got = 1'b1;
        end
        if_req = 1'b0;
        checks++;
        if (!got || if_rdata !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL rst_busy_fresh: if_ready_seen=%b if_rdata=%h, expected 1 0badf00d", got, if_rdata);
        end
        tick;
    endtask

    initial begin
        test_reset;
        test_load;
        test_both_request;
        test_starvation;
        test_store;
        test_ack_at_limit;
        test_timeout;
        test_reset_busy;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
